// File: rtl/fifo_dist_pkg.sv
// rtl/fifo_dist_pkg.sv - shared types and constants for the FIFO distribution reader
package fifo_dist_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  localparam int WORDS_READ_W = 16;

endpackage

// File: rtl/fifo_dist_skid.sv
// rtl/fifo_dist_skid.sv - two-entry output buffer; head entry drives the consumer
module fifo_dist_skid
  import fifo_dist_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  occ_t                  state;
  occ_t                  state_next;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  load_head;
  logic                  head_from_tail;
  logic                  load_tail;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (push) begin
          state_next = S_ONE;
          load_head  = 1'b1;
        end
      end
      S_ONE: begin
        case ({push, pop})
          2'b10: begin
            state_next = S_TWO;
            load_tail  = 1'b1;
          end
          2'b01:   state_next = S_EMPTY;
          2'b11:   load_head  = 1'b1;
          default: state_next = S_ONE;
        endcase
      end
      S_TWO: begin
        // Arrivals here are excluded by the read gating upstream.
        if (pop) begin
          head_from_tail = 1'b1;
          load_tail      = push;
          state_next     = push ? S_TWO : S_ONE;
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= push_data;
      end else if (head_from_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= push_data;
      end
    end
  end

  assign head_data = head_q;
  assign occ       = state;

  a_no_arrival_when_full: assert property (@(posedge clk) disable iff (arst)
    !(push && state == S_TWO));

endmodule

// File: rtl/fifo_dist_reader.sv
// rtl/fifo_dist_reader.sv - turns the sync FIFO's 1-cycle read latency into a valid/ready stream
module fifo_dist_reader
  import fifo_dist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    FIFO_empty,
  input  logic [DATA_WIDTH-1:0]   FIFO_rd_data,
  output logic                    FIFO_rd_en,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic [WORDS_READ_W-1:0] words_read
);

  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least 1");
  end

  logic                    started;
  logic                    inflight;
  logic                    pop;
  logic [1:0]              occ;
  logic [2:0]              level;
  logic [WORDS_READ_W-1:0] words_q;

  // Holds reads off until the first edge after reset release.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  assign pop        = out_valid & out_ready;
  assign level      = 3'(occ) + 3'(inflight) - 3'(pop);
  assign FIFO_rd_en = started & ~FIFO_empty & (level < 3'd2);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      inflight <= 1'b0;
      words_q  <= '0;
    end else begin
      inflight <= FIFO_rd_en;
      if (pop) begin
        words_q <= words_q + 1'b1;
      end
    end
  end

  fifo_dist_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .arst     (arst),
    .push     (inflight),
    .push_data(FIFO_rd_data),
    .pop      (pop),
    .head_data(out_data),
    .occ      (occ)
  );

  assign out_valid  = (occ != 2'd0);
  assign words_read = words_q;

endmodule

// File: tb/tb_fifo_dist_reader.sv
// tb/tb_fifo_dist_reader.sv - directed self-checking bench with a scoreboard for fifo_dist_reader
module tb_fifo_dist_reader;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        FIFO_empty;
  logic [7:0]  FIFO_rd_data = 8'h00;
  logic        FIFO_rd_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [15:0] words_read;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem[0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  always #5 clk = ~clk;

  fifo_dist_reader #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .FIFO_empty  (FIFO_empty),
    .FIFO_rd_data(FIFO_rd_data),
    .FIFO_rd_en  (FIFO_rd_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .words_read  (words_read)
  );

  // Sync FIFO model: word appears on rd_data the cycle after rd_en.
  assign FIFO_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!arst && FIFO_rd_en) begin
      FIFO_rd_data <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic tick();
    if (out_valid && out_ready) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rd_cnt;
    int rd_first;
    int rd_last;
    int acc_first;
    int acc_last;
    int fed;
    bit saw_fffe;

    repeat (2) @(negedge clk);
    chk("reset_rd_en", 32'(FIFO_rd_en), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_words", 32'(words_read), 32'd0);

    // Single word, including first-read timing after reset release.
    load(8'hA5);
    #1;
    chk("rd_en_in_reset", 32'(FIFO_rd_en), 32'd0);
    arst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rd_en_before_edge", 32'(FIFO_rd_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("single_rd_en_t", 32'(FIFO_rd_en), 32'd1);
    chk("single_valid_t", 32'(out_valid), 32'd0);
    tick();
    chk("single_valid_t1", 32'(out_valid), 32'd0);
    chk("single_rd_en_t1", 32'(FIFO_rd_en), 32'd0);
    tick();
    chk("single_valid_t2", 32'(out_valid), 32'd1);
    tick();
    chk("single_valid_t3", 32'(out_valid), 32'd0);
    chk("single_words", 32'(words_read), 32'd1);

    // Four-word stream at full rate.
    for (int i = 1; i <= 4; i++) load(8'(i));
    #1;
    rd_cnt = 0; rd_first = -1; rd_last = -1; acc_first = -1; acc_last = -1;
    for (int i = 0; i < 10; i++) begin
      if (FIFO_rd_en) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = i;
        rd_last = i;
      end
      if (out_valid && out_ready) begin
        if (acc_first < 0) acc_first = i;
        acc_last = i;
      end
      tick();
    end
    chk("stream_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("stream_rd_span", 32'(rd_last - rd_first), 32'd3);
    chk("stream_latency", 32'(acc_first - rd_first), 32'd2);
    chk("stream_acc_span", 32'(acc_last - acc_first), 32'd3);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_words", 32'(words_read), 32'd5);

    // Backpressure: only two reads may be outstanding.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) load(8'(i));
    #1;
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (FIFO_rd_en) rd_cnt++;
      if (out_valid) chk("bp_hold_data", 32'(out_data), 32'h01);
      tick();
    end
    chk("bp_rd_cnt", 32'(rd_cnt), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_rd_en", 32'(FIFO_rd_en), 32'd0);
    chk("bp_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_words", 32'(words_read), 32'd9);

    // Empty guard with toggling ready.
    for (int i = 0; i < 10; i++) begin
      out_ready = i[0];
      #1;
      chk("empty_rd_en", 32'(FIFO_rd_en), 32'd0);
      chk("empty_valid", 32'(out_valid), 32'd0);
      tick();
    end

    // Reset while one word is buffered and one is in flight.
    out_ready = 1'b0;
    load(8'h55);
    load(8'h66);
    #1;
    tick();
    tick();
    chk("mid_valid_before", 32'(out_valid), 32'd1);
    chk("mid_both_read", 32'(wr_ptr - rd_ptr), 32'd0);
    arst = 1'b1;
    #1;
    chk("mid_valid_reset", 32'(out_valid), 32'd0);
    chk("mid_words_reset", 32'(words_read), 32'd0);
    chk("mid_data_reset", 32'(out_data), 32'd0);
    chk("mid_rd_en_reset", 32'(FIFO_rd_en), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    out_ready = 1'b1;
    load(8'h77);
    for (int i = 0; i < 8; i++) tick();
    chk("mid_drained", 32'(exp_q.size()), 32'd0);
    chk("mid_words", 32'(words_read), 32'd1);

    // Counter wrap: 65536 more pops take the count from 1 through FFFE to 0001.
    fed = 0;
    saw_fffe = 1'b0;
    for (int c = 0; c < 70000 && (fed < 65536 || exp_q.size() != 0); c++) begin
      if (fed < 65536 && (wr_ptr - rd_ptr) < 4) begin
        load(8'(fed ^ 32'h3C));
        fed++;
      end
      if (words_read == 16'hFFFE) saw_fffe = 1'b1;
      tick();
    end
    repeat (4) tick();
    chk("wrap_saw_fffe", 32'(saw_fffe), 32'd1);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);
    chk("wrap_words", 32'(words_read), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_dist_reader.md
FIFO_DIST_READER -- requirements
Module: fifo_dist_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the word width, equal to the FIFO data width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, the depth of the attached FIFO, used only for width derivation.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port arst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port FIFO_empty, input, 1 bit: FIFO holds no readable word.
REQ-006 The block SHALL have port FIFO_rd_data, input, DATA_WIDTH bits: FIFO read word, valid in the cycle after FIFO_rd_en.
REQ-007 The block SHALL have port FIFO_rd_en, output, 1 bit: pop one word from the FIFO this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-009 The block SHALL have port out_data, output, DATA_WIDTH bits: head word for the consumer.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data when out_valid=1.
REQ-011 The block SHALL have port words_read, output, 16 bits: wrapping count of accepted words.

Function
- REQ-012 The block SHALL act as the distribution-side reader of the sync FIFO, converting its rd_en/1-cycle-latency read into a valid/ready stream.
- REQ-013 The block SHALL hold a 2-entry output buffer (occ 0..2) plus a 1-bit in-flight flag (inflight = FIFO_rd_en registered).
- REQ-014 Define pop = out_valid & out_ready; FIFO_rd_en SHALL equal !FIFO_empty & ((occ + inflight - pop) < 2), combinationally.
- REQ-015 FIFO_rd_en SHALL never assert while FIFO_empty=1.
- REQ-016 When inflight=1, FIFO_rd_data SHALL be written into the buffer at the clock edge ending that cycle.
- REQ-017 Buffer occupancy state SHALL be one of S_EMPTY (occ=0), S_ONE (occ=1) and S_TWO (occ=2).
- REQ-018 Each edge SHALL apply occ_next = occ + inflight - pop; simultaneous arrival and pop in S_ONE or S_TWO SHALL keep the state unchanged.
- REQ-019 out_valid SHALL be 1 exactly when occ != 0; out_data SHALL be the oldest buffered word, registered, with FIFO order preserved.
- REQ-020 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-021 Latency SHALL be: FIFO_rd_en at cycle t with occ=0 gives out_valid=1 at cycle t+2.
- REQ-022 Steady-state throughput SHALL be 1 word per cycle while the FIFO is non-empty and out_ready=1.
- REQ-023 An arrival SHALL never occur when occ=2; an arrival at occ=2 is a design error, flagged by assertion.
- REQ-024 words_read SHALL increment by 1 on each pop and wrap from 16'hFFFF to 0.

Reset
- REQ-025 On arst=1, immediately and independent of clk, the block SHALL force occ=0, inflight=0, out_valid=0, out_data=0, words_read=0, and FIFO_rd_en=0.
- REQ-026 A read in flight at reset assertion SHALL be discarded.
- REQ-027 The first FIFO_rd_en after reset SHALL occur no earlier than the first clk edge after arst deasserts.

Structure
- REQ-028 Package fifo_dist_pkg SHALL hold the occupancy enum (S_EMPTY, S_ONE, S_TWO) and the words_read width constant (16).
- REQ-029 The 2-entry buffer SHALL be sub-module fifo_dist_skid (push, pop, data in/out, occ out).
- REQ-030 The top level SHALL contain the rd_en logic, the inflight register and the counter.
- REQ-031 The block SHALL connect to the DIST_FIFO side of Sync_FIFO_Interface.

Verification
- REQ-032 Single word: FIFO holds 8'hA5, out_ready=1 -> rd_en at t, out_valid with 8'hA5 at t+2 for one cycle, words_read=1.
- REQ-033 Stream: FIFO holds 8'h01..8'h04, out_ready=1 -> rd_en 4 consecutive cycles, out_data 01,02,03,04 on consecutive cycles, words_read=4.
- REQ-034 Backpressure: FIFO holds 4 words, out_ready=0 -> exactly 2 rd_en pulses, occ=2, out_data=8'h01 stable; release ready -> remaining order intact.
- REQ-035 Empty guard: FIFO_empty=1 for 10 cycles with out_ready toggling -> rd_en=0 and out_valid=0 throughout.
- REQ-036 Reset mid-stream: arst pulse while inflight=1 and occ=1 -> out_valid=0 and words_read=0 same cycle; the discarded word never appears.
- REQ-037 Counter wrap: preload 16'hFFFE, pop 3 words -> words_read=16'h0001.
